// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage load/store sequencer.
//   SIZE_* : RAM access size encodings (byte, half, word, illegal)
//   mau_state_e : sequencer state encoding
//   DEF_MEM_BYTES / DEF_MAX_BURST : default parameter values
//   size_bytes() : number of bytes touched by one beat of a given size
package mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_BAD  = 2'b11;

   localparam int unsigned DEF_MEM_BYTES = 256;
   localparam int unsigned DEF_MAX_BURST = 16;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StCheck   = 2'b01,
      StAccess  = 2'b10,
      StCapture = 2'b11
   } mau_state_e;

   // Illegal size reports 4 bytes; such requests fault on size anyway.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] nb;
      case (size)
         SIZE_BYTE: nb = 3'd1;
         SIZE_HALF: nb = 3'd2;
         default:   nb = 3'd4;
      endcase
      return nb;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request handshake between the EX/MEM stage and the sequencer.
//   req_valid/req_ready : handshake, accept when both high
//   req_load/size/signed/addr/wdata/count/rd : request fields, latched on accept
//   beat_idx   : current burst beat, used to read burst store data
//   beat_wdata : burst store data for beat_idx
// master = requester (pipeline), slave = mem_access_unit.
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_load;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_count;
   logic [3:0]  req_rd;
   logic [3:0]  beat_idx;
   logic [31:0] beat_wdata;

   modport master (
      output req_valid, req_load, req_size, req_signed, req_addr, req_wdata, req_count,
             req_rd, beat_wdata,
      input  req_ready, beat_idx
   );

   modport slave (
      input  req_valid, req_load, req_size, req_signed, req_addr, req_wdata, req_count,
             req_rd, beat_wdata,
      output req_ready, beat_idx
   );

endinterface

// File: rtl/mem_load_extend.sv
// mem_load_extend: combinational load-data extension.
//   size     in  2   access size (byte/half/word)
//   sign_ext in  1   1 = sign-extend, 0 = zero-extend
//   raw      in  32  right-justified RAM data
//   result   out 32  extended value
module mem_load_extend
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] raw,
   output logic [31:0] result
);

   always_comb begin
      result = raw;
      case (size)
         SIZE_BYTE: result = {{24{sign_ext & raw[7]}}, raw[7:0]};
         SIZE_HALF: result = {{16{sign_ext & raw[15]}}, raw[15:0]};
         default:   result = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer in front of a 256x8 data RAM.
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   req          : request handshake and burst store data (mem_access_unit_if.slave)
//   ram_en/rw/addr/din/size : RAM command port; ram_dout : RAM read data
//   wb_valid/data/rd        : one pulse per load beat toward write-back
//   done  : one-cycle pulse when a request ends
//   fault : pulses with done when a request is rejected (no RAM access)
// Flow: IDLE -> CHECK -> (ACCESS -> CAPTURE)xN -> IDLE. Each beat takes two cycles.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
   input  logic              clk,
   input  logic              reset,
   mem_access_unit_if.slave  req,
   output logic              ram_en,
   output logic              ram_rw,
   output logic [31:0]       ram_addr,
   output logic [31:0]       ram_din,
   output logic [1:0]        ram_size,
   input  logic [31:0]       ram_dout,
   output logic              wb_valid,
   output logic [31:0]       wb_data,
   output logic [3:0]        wb_rd,
   output logic              done,
   output logic              fault
);

   mau_state_e  state_q, state_d;

   // Latched request
   logic        load_q;
   logic        signed_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [4:0]  count_q;
   logic [3:0]  rd_q;

   logic [3:0]  beat_q, beat_d;

   // Registered write-back / completion
   logic        wb_valid_q;
   logic [31:0] wb_data_q;
   logic [3:0]  wb_rd_q;
   logic        done_q;

   logic        accept;
   logic        bad_req;
   logic        last_beat;
   logic [4:0]  n_beats;
   logic [33:0] last_byte;
   logic [31:0] ext_data;

   // Ready stays low through the done cycle so a new accept lands one cycle later.
   assign req.req_ready = (state_q == StIdle) && !done_q;
   assign accept        = req.req_valid && req.req_ready;
   assign req.beat_idx  = beat_q;

   // Legality check on the latched request. The last-byte sum is kept wide so that
   // an address near the top of the 32-bit space cannot wrap back into range.
   always_comb begin
      n_beats   = (count_q <= 5'd1) ? 5'd1 : count_q;
      last_byte = {2'b00, addr_q} + {27'd0, n_beats - 5'd1, 2'b00}
                  + 34'(size_bytes(size_q)) - 34'd1;
      bad_req   = 1'b0;
      if (size_q == SIZE_BAD) begin
         bad_req = 1'b1;
      end
      if ((size_q == SIZE_HALF) && addr_q[0]) begin
         bad_req = 1'b1;
      end
      if ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00)) begin
         bad_req = 1'b1;
      end
      if ((count_q > 5'd1) && (size_q != SIZE_WORD)) begin
         bad_req = 1'b1;
      end
      if (32'(count_q) > MAX_BURST) begin
         bad_req = 1'b1;
      end
      if (last_byte >= 34'(MEM_BYTES)) begin
         bad_req = 1'b1;
      end
   end

   assign last_beat = ({1'b0, beat_q} == (n_beats - 5'd1));

   // Next state and RAM strobes
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      fault   = 1'b0;
      ram_en  = 1'b0;
      ram_rw  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StCheck;
               beat_d  = 4'd0;
            end
         end
         StCheck: begin
            if (bad_req) begin
               fault   = 1'b1;
               state_d = StIdle;
            end else begin
               state_d = StAccess;
            end
         end
         StAccess: begin
            ram_en  = 1'b1;
            ram_rw  = !load_q;
            state_d = StCapture;
         end
         StCapture: begin
            // Command held with ram_en low while read data settles.
            ram_rw = !load_q;
            if (last_beat) begin
               state_d = StIdle;
            end else begin
               state_d = StAccess;
               beat_d  = beat_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign ram_addr = addr_q + {26'd0, beat_q, 2'b00};
   assign ram_size = size_q;
   // Single-beat stores carry their data in the request; bursts fetch it per beat.
   assign ram_din  = (count_q <= 5'd1) ? wdata_q : req.beat_wdata;

   assign done     = done_q | fault;
   assign wb_valid = wb_valid_q;
   assign wb_data  = wb_data_q;
   assign wb_rd    = wb_rd_q;

   mem_load_extend u_extend (
      .size     (size_q),
      .sign_ext (signed_q),
      .raw      (ram_dout),
      .result   (ext_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         beat_q   <= 4'd0;
         load_q   <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         count_q  <= 5'd0;
         rd_q     <= 4'd0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (accept) begin
            load_q   <= req.req_load;
            signed_q <= req.req_signed;
            size_q   <= req.req_size;
            addr_q   <= req.req_addr;
            wdata_q  <= req.req_wdata;
            count_q  <= req.req_count;
            rd_q     <= req.req_rd;
         end
      end
   end

   // Load data is captured at the end of CAPTURE and presented the following cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= 32'd0;
         wb_rd_q    <= 4'd0;
         done_q     <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         done_q     <= 1'b0;
         if (state_q == StCapture) begin
            done_q <= last_beat;
            if (load_q) begin
               wb_valid_q <= 1'b1;
               wb_data_q  <= ext_data;
               wb_rd_q    <= rd_q + beat_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// A behavioural 256x8 big-endian RAM stands in for data_ram256x8; it is
// precharged with mem[i] = 8'h85 ^ i, so mem[0] = 8'h85.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ram_en;
   logic        ram_rw;
   logic [31:0] ram_addr;
   logic [31:0] ram_din;
   logic [1:0]  ram_size;
   logic [31:0] ram_dout;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [3:0]  wb_rd;
   logic        done;
   logic        fault;

   int errors = 0;
   int checks = 0;

   mem_access_unit_if rq ();

   mem_access_unit dut (
      .clk      (clk),
      .reset    (reset),
      .req      (rq),
      .ram_en   (ram_en),
      .ram_rw   (ram_rw),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_size (ram_size),
      .ram_dout (ram_dout),
      .wb_valid (wb_valid),
      .wb_data  (wb_data),
      .wb_rd    (wb_rd),
      .done     (done),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   // Register-file stand-in for burst store data.
   assign rq.beat_wdata = {28'hC0FFEE0, rq.beat_idx};

   // RAM model
   logic [7:0] mem [0:255];
   logic [7:0] a0, a1, a2, a3;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h85 ^ 8'(i);
   end

   always_comb begin
      a0 = ram_addr[7:0];
      a1 = a0 + 8'd1;
      a2 = a0 + 8'd2;
      a3 = a0 + 8'd3;
      case (ram_size)
         2'b00:   ram_dout = {24'd0, mem[a0]};
         2'b01:   ram_dout = {16'd0, mem[a0], mem[a1]};
         default: ram_dout = {mem[a0], mem[a1], mem[a2], mem[a3]};
      endcase
   end

   always @(posedge clk) begin
      if (ram_en && ram_rw) begin
         case (ram_size)
            2'b00: mem[a0] <= ram_din[7:0];
            2'b01: begin
               mem[a0] <= ram_din[15:8];
               mem[a1] <= ram_din[7:0];
            end
            default: begin
               mem[a0] <= ram_din[31:24];
               mem[a1] <= ram_din[23:16];
               mem[a2] <= ram_din[15:8];
               mem[a3] <= ram_din[7:0];
            end
         endcase
      end
   end

   // Per-cycle samples, index k = cycles after the accept edge
   logic        s_en   [0:15];
   logic        s_rw   [0:15];
   logic [1:0]  s_size [0:15];
   logic [31:0] s_addr [0:15];
   logic        s_wbv  [0:15];
   logic [31:0] s_wbd  [0:15];
   logic [3:0]  s_wbrd [0:15];
   logic        s_done [0:15];
   logic        s_flt  [0:15];
   logic        s_rdy  [0:15];

   // Called #1 after a rising edge; returns #1 after the accept edge.
   task automatic issue(input logic load, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] count, input logic [3:0] rd);
      int guard = 0;
      while (rq.req_ready !== 1'b1 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checks++;
      if (rq.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_wait: req_ready=%b required 1", rq.req_ready);
      end
      rq.req_valid  = 1'b1;
      rq.req_load   = load;
      rq.req_size   = size;
      rq.req_signed = sgn;
      rq.req_addr   = addr;
      rq.req_wdata  = wdata;
      rq.req_count  = count;
      rq.req_rd     = rd;
      @(posedge clk);
      #1;
      rq.req_valid = 1'b0;
   endtask

   task automatic watch(input int n);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         s_en[k]   = ram_en;
         s_rw[k]   = ram_rw;
         s_size[k] = ram_size;
         s_addr[k] = ram_addr;
         s_wbv[k]  = wb_valid;
         s_wbd[k]  = wb_data;
         s_wbrd[k] = wb_rd;
         s_done[k] = done;
         s_flt[k]  = fault;
         s_rdy[k]  = rq.req_ready;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks += 7;
      if (rq.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", rq.req_ready); end
      if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
      if (ram_rw !== 1'b0) begin errors++; $display("FAIL rst_ram_rw: got %b want 0", ram_rw); end
      if (ram_addr !== 32'd0) begin errors++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr); end
      if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", fault); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_word_load();
      issue(1'b1, 2'b10, 1'b0, 32'd4, 32'd0, 5'd1, 4'd7);
      watch(5);
      for (int k = 1; k <= 5; k++) begin
         checks += 3;
         if (s_en[k] !== (k == 2)) begin errors++; $display("FAIL wl_en[%0d]: got %b want %b", k, s_en[k], k == 2); end
         if (s_wbv[k] !== (k == 4)) begin errors++; $display("FAIL wl_wbv[%0d]: got %b want %b", k, s_wbv[k], k == 4); end
         if (s_done[k] !== (k == 4)) begin errors++; $display("FAIL wl_done[%0d]: got %b want %b", k, s_done[k], k == 4); end
      end
      checks += 7;
      if (s_size[2] !== 2'b10) begin errors++; $display("FAIL wl_size: got %b want 10", s_size[2]); end
      if (s_rw[2] !== 1'b0) begin errors++; $display("FAIL wl_rw: got %b want 0", s_rw[2]); end
      if (s_addr[2] !== 32'd4) begin errors++; $display("FAIL wl_addr: got %h want 4", s_addr[2]); end
      if (s_wbd[4] !== 32'h81808382) begin errors++; $display("FAIL wl_data: got %h want 81808382", s_wbd[4]); end
      if (s_wbrd[4] !== 4'd7) begin errors++; $display("FAIL wl_rd: got %0d want 7", s_wbrd[4]); end
      if (s_rdy[4] !== 1'b0) begin errors++; $display("FAIL wl_rdy_done: got %b want 0", s_rdy[4]); end
      if (s_rdy[5] !== 1'b1) begin errors++; $display("FAIL wl_rdy_after: got %b want 1", s_rdy[5]); end
   endtask

   task automatic test_byte_load();
      issue(1'b1, 2'b00, 1'b1, 32'd0, 32'd0, 5'd0, 4'd1);
      watch(4);
      checks += 2;
      if (s_wbv[4] !== 1'b1) begin errors++; $display("FAIL bl_s_wbv: got %b want 1", s_wbv[4]); end
      if (s_wbd[4] !== 32'hFFFFFF85) begin errors++; $display("FAIL bl_signed: got %h want ffffff85", s_wbd[4]); end
      issue(1'b1, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 4'd1);
      watch(4);
      checks += 2;
      if (s_size[2] !== 2'b00) begin errors++; $display("FAIL bl_size: got %b want 00", s_size[2]); end
      if (s_wbd[4] !== 32'h00000085) begin errors++; $display("FAIL bl_unsigned: got %h want 00000085", s_wbd[4]); end
   endtask

   task automatic test_half_store_load();
      issue(1'b0, 2'b01, 1'b0, 32'd2, 32'h1234FFD3, 5'd0, 4'd0);
      watch(5);
      for (int k = 1; k <= 5; k++) begin
         checks += 2;
         if (s_wbv[k] !== 1'b0) begin errors++; $display("FAIL hs_wbv[%0d]: got %b want 0", k, s_wbv[k]); end
         if (s_done[k] !== (k == 4)) begin errors++; $display("FAIL hs_done[%0d]: got %b want %b", k, s_done[k], k == 4); end
      end
      checks += 6;
      if (s_en[2] !== 1'b1) begin errors++; $display("FAIL hs_en: got %b want 1", s_en[2]); end
      if (s_rw[2] !== 1'b1) begin errors++; $display("FAIL hs_rw: got %b want 1", s_rw[2]); end
      if (mem[2] !== 8'hFF) begin errors++; $display("FAIL hs_mem2: got %h want ff", mem[2]); end
      if (mem[3] !== 8'hD3) begin errors++; $display("FAIL hs_mem3: got %h want d3", mem[3]); end
      if (mem[1] !== 8'h84) begin errors++; $display("FAIL hs_mem1: got %h want 84", mem[1]); end
      if (mem[4] !== 8'h81) begin errors++; $display("FAIL hs_mem4: got %h want 81", mem[4]); end
      issue(1'b1, 2'b01, 1'b0, 32'd2, 32'd0, 5'd0, 4'd3);
      watch(4);
      checks++;
      if (s_wbd[4] !== 32'h0000FFD3) begin errors++; $display("FAIL hl_unsigned: got %h want 0000ffd3", s_wbd[4]); end
      issue(1'b1, 2'b01, 1'b1, 32'd2, 32'd0, 5'd0, 4'd3);
      watch(4);
      checks++;
      if (s_wbd[4] !== 32'hFFFFFFD3) begin errors++; $display("FAIL hl_signed: got %h want ffffffd3", s_wbd[4]); end
   endtask

   task automatic test_fault();
      logic [1:0]  fsz  [0:5];
      logic [31:0] fadr [0:5];
      logic [4:0]  fcnt [0:5];
      fsz  = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
      fadr = '{32'd6, 32'd252, 32'd0, 32'd0, 32'd0, 32'd1};
      fcnt = '{5'd1, 5'd2, 5'd17, 5'd2, 5'd1, 5'd1};
      for (int t = 0; t < 6; t++) begin
         issue(1'b1, fsz[t], 1'b0, fadr[t], 32'd0, fcnt[t], 4'd0);
         watch(4);
         checks += 3;
         if (s_flt[1] !== 1'b1) begin errors++; $display("FAIL flt%0d_fault: got %b want 1", t, s_flt[1]); end
         if (s_done[1] !== 1'b1) begin errors++; $display("FAIL flt%0d_done: got %b want 1", t, s_done[1]); end
         if (s_rdy[2] !== 1'b1) begin errors++; $display("FAIL flt%0d_rdy: got %b want 1", t, s_rdy[2]); end
         for (int k = 1; k <= 4; k++) begin
            checks += 2;
            if (s_en[k] !== 1'b0) begin errors++; $display("FAIL flt%0d_en[%0d]: got %b want 0", t, k, s_en[k]); end
            if (s_wbv[k] !== 1'b0) begin errors++; $display("FAIL flt%0d_wbv[%0d]: got %b want 0", t, k, s_wbv[k]); end
         end
      end
      // Last legal word of memory
      issue(1'b1, 2'b10, 1'b0, 32'd252, 32'd0, 5'd1, 4'd9);
      watch(4);
      checks += 3;
      if (s_flt[1] !== 1'b0) begin errors++; $display("FAIL edge_fault: got %b want 0", s_flt[1]); end
      if (s_en[2] !== 1'b1) begin errors++; $display("FAIL edge_en: got %b want 1", s_en[2]); end
      if (s_wbd[4] !== 32'h79787B7A) begin errors++; $display("FAIL edge_data: got %h want 79787b7a", s_wbd[4]); end
   endtask

   task automatic test_burst_load();
      logic [31:0] bd [0:3];
      bd = '{32'h8D8C8F8E, 32'h89888B8A, 32'h95949796, 32'h91909392};
      issue(1'b1, 2'b10, 1'b0, 32'd8, 32'd0, 5'd4, 4'd2);
      watch(11);
      for (int k = 1; k <= 11; k++) begin
         checks += 3;
         if (s_en[k] !== (k % 2 == 0 && k <= 8)) begin
            errors++; $display("FAIL bu_en[%0d]: got %b want %b", k, s_en[k], k % 2 == 0 && k <= 8);
         end
         if (s_wbv[k] !== (k % 2 == 0 && k >= 4 && k <= 10)) begin
            errors++; $display("FAIL bu_wbv[%0d]: got %b", k, s_wbv[k]);
         end
         if (s_done[k] !== (k == 10)) begin
            errors++; $display("FAIL bu_done[%0d]: got %b want %b", k, s_done[k], k == 10);
         end
      end
      for (int b = 0; b < 4; b++) begin
         checks += 3;
         if (s_addr[2 + 2 * b] !== 32'(8 + 4 * b)) begin
            errors++; $display("FAIL bu_addr%0d: got %0d want %0d", b, s_addr[2 + 2 * b], 8 + 4 * b);
         end
         if (s_wbrd[4 + 2 * b] !== 4'(2 + b)) begin
            errors++; $display("FAIL bu_rd%0d: got %0d want %0d", b, s_wbrd[4 + 2 * b], 2 + b);
         end
         if (s_wbd[4 + 2 * b] !== bd[b]) begin
            errors++; $display("FAIL bu_data%0d: got %h want %h", b, s_wbd[4 + 2 * b], bd[b]);
         end
      end
      checks++;
      if (s_addr[3] !== 32'd8) begin errors++; $display("FAIL bu_hold: got %0d want 8", s_addr[3]); end
   endtask

   task automatic test_burst_store();
      issue(1'b0, 2'b10, 1'b0, 32'd32, 32'hDEADBEEF, 5'd2, 4'd0);
      watch(7);
      for (int k = 1; k <= 7; k++) begin
         checks += 2;
         if (s_wbv[k] !== 1'b0) begin errors++; $display("FAIL bs_wbv[%0d]: got %b want 0", k, s_wbv[k]); end
         if (s_done[k] !== (k == 6)) begin errors++; $display("FAIL bs_done[%0d]: got %b want %b", k, s_done[k], k == 6); end
      end
      checks += 2;
      if ({mem[32], mem[33], mem[34], mem[35]} !== 32'hC0FFEE00) begin
         errors++; $display("FAIL bs_word0: got %h want c0ffee00", {mem[32], mem[33], mem[34], mem[35]});
      end
      if ({mem[36], mem[37], mem[38], mem[39]} !== 32'hC0FFEE01) begin
         errors++; $display("FAIL bs_word1: got %h want c0ffee01", {mem[36], mem[37], mem[38], mem[39]});
      end
   endtask

   task automatic test_reset_mid_burst();
      issue(1'b1, 2'b10, 1'b0, 32'd8, 32'd0, 5'd4, 4'd2);
      watch(6);
      checks++;
      if (s_en[6] !== 1'b1) begin errors++; $display("FAIL rm_pre_en: got %b want 1", s_en[6]); end
      // Now in CAPTURE of beat 2; reset asserted mid-cycle, away from any edge.
      #2;
      reset = 1'b1;
      #1;
      checks += 4;
      if (ram_en !== 1'b0) begin errors++; $display("FAIL rm_en: got %b want 0", ram_en); end
      if (wb_valid !== 1'b0) begin errors++; $display("FAIL rm_wbv: got %b want 0", wb_valid); end
      if (rq.req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", rq.req_ready); end
      if (ram_addr !== 32'd0) begin errors++; $display("FAIL rm_addr: got %h want 0", ram_addr); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      watch(3);
      for (int k = 1; k <= 3; k++) begin
         checks += 3;
         if (s_wbv[k] !== 1'b0) begin errors++; $display("FAIL rm_post_wbv[%0d]: got %b want 0", k, s_wbv[k]); end
         if (s_done[k] !== 1'b0) begin errors++; $display("FAIL rm_post_done[%0d]: got %b want 0", k, s_done[k]); end
         if (s_rdy[k] !== 1'b1) begin errors++; $display("FAIL rm_post_rdy[%0d]: got %b want 1", k, s_rdy[k]); end
      end
      issue(1'b1, 2'b10, 1'b0, 32'd4, 32'd0, 5'd1, 4'd5);
      watch(4);
      checks += 3;
      if (s_wbv[4] !== 1'b1) begin errors++; $display("FAIL rm_load_wbv: got %b want 1", s_wbv[4]); end
      if (s_wbd[4] !== 32'h81808382) begin errors++; $display("FAIL rm_load_data: got %h want 81808382", s_wbd[4]); end
      if (s_wbrd[4] !== 4'd5) begin errors++; $display("FAIL rm_load_rd: got %0d want 5", s_wbrd[4]); end
   endtask

   initial begin
      rq.req_valid  = 1'b0;
      rq.req_load   = 1'b0;
      rq.req_size   = 2'b00;
      rq.req_signed = 1'b0;
      rq.req_addr   = 32'd0;
      rq.req_wdata  = 32'd0;
      rq.req_count  = 5'd0;
      rq.req_rd     = 4'd0;
      reset         = 1'b1;
      test_reset();
      test_word_load();
      test_byte_load();
      test_half_store_load();
      test_fault();
      test_burst_load();
      test_burst_store();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
